// File: rtl/sa_rdata_channel_pkg.sv
// Shared constants for the slave-side read-data return path.
// Holds the RRESP width and the AXI response encodings.
package sa_rdata_channel_pkg;

  localparam int RRESP_W = 2;

  typedef enum logic [RRESP_W-1:0] {
    RRESP_OKAY   = 2'd0,
    RRESP_EXOKAY = 2'd1,
    RRESP_SLVERR = 2'd2,
    RRESP_DECERR = 2'd3
  } rresp_e;

endpackage

// File: rtl/sa_rdata_channel_fifo.sv
// Codebase show-ahead FIFO: data_o always presents the oldest entry.
// Pushes while full and pops while empty are ignored.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  ACLK_i,
  input  logic                  ARESET_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;

  assign full_o  = (count == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count == '0);
  assign push    = wr_en_i & ~full_o;
  assign pop     = rd_en_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset; occupancy tracking alone defines validity.
  always_ff @(posedge ACLK_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/sa_rdata_channel.sv
// Slave-side R return path: steers slave beats to the issuing master in AR order,
// counts beats against ARLEN to generate RLAST and flags slave RLAST mismatches.
module sa_rdata_channel
  import sa_rdata_channel_pkg::*;
#(
  parameter int MST_AMT          = 3,
  parameter int OUTSTANDING_AMT  = 8,
  parameter int MST_ID_W         = $clog2(MST_AMT),
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_DATA_LEN_W = 3
) (
  input  logic                           ACLK_i,
  input  logic                           ARESET_i,
  input  logic [MST_ID_W-1:0]            AR_mst_id_i,
  input  logic [TRANS_DATA_LEN_W-1:0]    AR_AxLEN_i,
  input  logic                           AR_fifo_order_wr_en_i,
  output logic                           AR_stall_o,
  input  logic [DATA_WIDTH-1:0]          s_RDATA_i,
  input  logic [RRESP_W-1:0]             s_RRESP_i,
  input  logic                           s_RLAST_i,
  input  logic                           s_RVALID_i,
  output logic                           s_RREADY_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]  dsp_RDATA_o,
  output logic [RRESP_W*MST_AMT-1:0]     dsp_RRESP_o,
  output logic [MST_AMT-1:0]             dsp_RLAST_o,
  output logic [MST_AMT-1:0]             dsp_RVALID_o,
  input  logic [MST_AMT-1:0]             dsp_RREADY_i,
  output logic                           rlast_err_o
);

  localparam int ENT_W = MST_ID_W + TRANS_DATA_LEN_W;

  logic [ENT_W-1:0]            head;
  logic [MST_ID_W-1:0]         head_mst;
  logic [TRANS_DATA_LEN_W-1:0] head_len;
  logic                        order_empty;
  logic                        order_full;
  logic [TRANS_DATA_LEN_W-1:0] beat_ctn_r;
  logic                        counted_last;
  logic                        s_hs;
  logic                        rready_sel;

  logic                        out_valid;
  logic [MST_ID_W-1:0]         out_mst;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [RRESP_W-1:0]          out_resp;
  logic                        out_last;

  fifo #(
    .DATA_WIDTH (ENT_W),
    .FIFO_DEPTH (OUTSTANDING_AMT)
  ) u_order_fifo (
    .ACLK_i   (ACLK_i),
    .ARESET_i (ARESET_i),
    .data_i   ({AR_mst_id_i, AR_AxLEN_i}),
    .wr_en_i  (AR_fifo_order_wr_en_i),
    .rd_en_i  (s_hs & counted_last),
    .data_o   (head),
    .empty_o  (order_empty),
    .full_o   (order_full)
  );

  assign {head_mst, head_len} = head;
  assign counted_last = (beat_ctn_r == head_len);
  assign AR_stall_o   = order_full;
  // Ready only looks at registered state and downstream ready, never at s_RVALID_i.
  assign s_RREADY_o   = ~order_empty & (~out_valid | rready_sel);
  assign s_hs         = s_RVALID_i & s_RREADY_o;

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      beat_ctn_r <= '0;
    end else if (s_hs) begin
      beat_ctn_r <= counted_last ? '0 : beat_ctn_r + TRANS_DATA_LEN_W'(1);
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      out_valid <= 1'b0;
      out_mst   <= '0;
      out_data  <= '0;
      out_resp  <= '0;
      out_last  <= 1'b0;
    end else if (s_hs) begin
      out_valid <= 1'b1;
      out_mst   <= head_mst;
      out_data  <= s_RDATA_i;
      out_resp  <= s_RRESP_i;
      out_last  <= counted_last;
    end else if (out_valid && rready_sel) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky until reset; routing never depends on the slave's own RLAST.
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      rlast_err_o <= 1'b0;
    end else if (s_hs && (s_RLAST_i != counted_last)) begin
      rlast_err_o <= 1'b1;
    end
  end

  always_comb begin
    dsp_RVALID_o = '0;
    dsp_RLAST_o  = '0;
    dsp_RDATA_o  = '0;
    dsp_RRESP_o  = '0;
    rready_sel   = 1'b0;
    for (int m = 0; m < MST_AMT; m++) begin
      dsp_RDATA_o[DATA_WIDTH*m +: DATA_WIDTH] = out_data;
      dsp_RRESP_o[RRESP_W*m +: RRESP_W]       = out_resp;
      if (out_mst == MST_ID_W'(m)) begin
        dsp_RVALID_o[m] = out_valid;
        dsp_RLAST_o[m]  = out_last;
        rready_sel      = dsp_RREADY_i[m];
      end
    end
  end

endmodule

// File: tb/tb_sa_rdata_channel.sv
// Bench for sa_rdata_channel: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of AR order and beat delivery.
module tb_sa_rdata_channel;
  import sa_rdata_channel_pkg::*;

  localparam int MST_AMT = 3;
  localparam int OUT_AMT = 8;
  localparam int MST_ID_W = 2;
  localparam int DW = 32;
  localparam int LW = 3;

  logic                    ACLK_i = 1'b0;
  logic                    ARESET_i;
  logic [MST_ID_W-1:0]     AR_mst_id_i;
  logic [LW-1:0]           AR_AxLEN_i;
  logic                    AR_fifo_order_wr_en_i;
  logic                    AR_stall_o;
  logic [DW-1:0]           s_RDATA_i;
  logic [1:0]              s_RRESP_i;
  logic                    s_RLAST_i;
  logic                    s_RVALID_i;
  logic                    s_RREADY_o;
  logic [DW*MST_AMT-1:0]   dsp_RDATA_o;
  logic [2*MST_AMT-1:0]    dsp_RRESP_o;
  logic [MST_AMT-1:0]      dsp_RLAST_o;
  logic [MST_AMT-1:0]      dsp_RVALID_o;
  logic [MST_AMT-1:0]      dsp_RREADY_i;
  logic                    rlast_err_o;

  always #5 ACLK_i = ~ACLK_i;

  sa_rdata_channel #(
    .MST_AMT(MST_AMT), .OUTSTANDING_AMT(OUT_AMT), .MST_ID_W(MST_ID_W),
    .DATA_WIDTH(DW), .TRANS_DATA_LEN_W(LW)
  ) dut (
    .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
    .AR_mst_id_i(AR_mst_id_i), .AR_AxLEN_i(AR_AxLEN_i),
    .AR_fifo_order_wr_en_i(AR_fifo_order_wr_en_i), .AR_stall_o(AR_stall_o),
    .s_RDATA_i(s_RDATA_i), .s_RRESP_i(s_RRESP_i), .s_RLAST_i(s_RLAST_i),
    .s_RVALID_i(s_RVALID_i), .s_RREADY_o(s_RREADY_o),
    .dsp_RDATA_o(dsp_RDATA_o), .dsp_RRESP_o(dsp_RRESP_o), .dsp_RLAST_o(dsp_RLAST_o),
    .dsp_RVALID_o(dsp_RVALID_o), .dsp_RREADY_i(dsp_RREADY_i), .rlast_err_o(rlast_err_o)
  );

  typedef struct { int mst; int len; } txn_t;
  typedef struct { int mst; logic [DW-1:0] data; logic [1:0] resp; logic last; } beat_t;

  txn_t  txn_q[$];
  beat_t out_q[$];
  int    beat_idx;
  bit    err_m;
  bit    just_reset;
  bit    last_s_hs;
  int    n_vec;
  int    n_err;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic exp_slast();
    if (txn_q.size() == 0) return 1'b0;
    return (beat_idx == txn_q[0].len);
  endfunction

  task automatic model_clear();
    txn_q.delete();
    out_q.delete();
    beat_idx = 0;
    err_m    = 1'b0;
  endtask

  // Entered just after a falling edge with inputs already driven; leaves at the next falling edge.
  task automatic step();
    logic [MST_AMT-1:0] exp_vld;
    logic               exp_rdy;
    logic               s_hs;
    logic               d_hs;
    bit                 full_pre;
    int                 m;
    beat_t              b;
    #1;
    exp_vld = '0;
    exp_rdy = 1'b0;
    d_hs    = 1'b0;
    if (out_q.size() > 0) begin
      m = out_q[0].mst;
      exp_vld[m] = 1'b1;
      d_hs = dsp_RREADY_i[m];
    end
    exp_rdy = (txn_q.size() > 0) && ((out_q.size() == 0) || d_hs);
    check_val("rvalid", dsp_RVALID_o, exp_vld);
    check_val("s_rready", s_RREADY_o, exp_rdy);
    check_val("ar_stall", AR_stall_o, txn_q.size() == OUT_AMT);
    check_val("rlast_err", rlast_err_o, err_m);
    if (out_q.size() > 0) begin
      check_val("rdata", dsp_RDATA_o[DW*m +: DW], out_q[0].data);
      check_val("rresp", dsp_RRESP_o[2*m +: 2], out_q[0].resp);
      check_val("rlast", dsp_RLAST_o, out_q[0].last ? exp_vld : '0);
    end
    if (just_reset) begin
      check_val("rst_rdata", dsp_RDATA_o, '0);
      check_val("rst_rresp", dsp_RRESP_o, '0);
      check_val("rst_rlast", dsp_RLAST_o, '0);
    end
    s_hs      = s_RVALID_i & s_RREADY_o;
    last_s_hs = s_hs;
    full_pre  = (txn_q.size() == OUT_AMT);
    @(posedge ACLK_i);
    if (ARESET_i) begin
      model_clear();
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (d_hs) void'(out_q.pop_front());
      if (s_hs) begin
        if (txn_q.size() == 0) begin
          check_val("orphan_beat", 1, 0);
        end else begin
          b.mst  = txn_q[0].mst;
          b.data = s_RDATA_i;
          b.resp = s_RRESP_i;
          b.last = (beat_idx == txn_q[0].len);
          if (s_RLAST_i != b.last) err_m = 1'b1;
          out_q.push_back(b);
          if (b.last) begin
            void'(txn_q.pop_front());
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
      end
      if (AR_fifo_order_wr_en_i && !full_pre)
        txn_q.push_back('{mst: int'(AR_mst_id_i), len: int'(AR_AxLEN_i)});
    end
    @(negedge ACLK_i);
  endtask

  task automatic idle_inputs();
    AR_fifo_order_wr_en_i = 1'b0;
    AR_mst_id_i = '0;
    AR_AxLEN_i  = '0;
    s_RVALID_i  = 1'b0;
    s_RDATA_i   = '0;
    s_RRESP_i   = RRESP_OKAY;
    s_RLAST_i   = 1'b0;
  endtask

  task automatic push_ar(input int id, input int len);
    AR_fifo_order_wr_en_i = 1'b1;
    AR_mst_id_i = MST_ID_W'(id);
    AR_AxLEN_i  = LW'(len);
    step();
    AR_fifo_order_wr_en_i = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [1:0] r, input logic last);
    s_RVALID_i = 1'b1;
    s_RDATA_i  = d;
    s_RRESP_i  = r;
    s_RLAST_i  = last;
    step();
    s_RVALID_i = 1'b0;
  endtask

  initial begin
    int hs_cnt;
    int guard;
    n_vec = 0;
    n_err = 0;
    model_clear();
    idle_inputs();
    dsp_RREADY_i = '1;
    ARESET_i = 1'b1;
    repeat (2) @(posedge ACLK_i);
    @(negedge ACLK_i);
    just_reset = 1'b1;
    ARESET_i = 1'b0;
    step();

    // Single beat, len=0, to master 2
    push_ar(2, 0);
    beat(32'hA5A5A5A5, RRESP_OKAY, 1'b1);
    repeat (2) step();

    // Two bursts back to back; every cycle must accept a beat
    push_ar(0, 3);
    push_ar(1, 1);
    hs_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      s_RVALID_i = 1'b1;
      s_RDATA_i  = $urandom;
      s_RRESP_i  = 2'(i);
      s_RLAST_i  = exp_slast();
      step();
      hs_cnt += int'(last_s_hs);
    end
    s_RVALID_i = 1'b0;
    check_val("b2b_beats", hs_cnt, 6);
    repeat (2) step();

    // Backpressure on master 0 mid-burst
    push_ar(0, 3);
    for (int i = 0; i < 10; i++) begin
      dsp_RREADY_i = (i >= 2 && i < 7) ? 3'b110 : 3'b111;
      s_RVALID_i = 1'b1;
      s_RDATA_i  = 32'h1000 + i;
      s_RLAST_i  = exp_slast();
      step();
    end
    s_RVALID_i = 1'b0;
    dsp_RREADY_i = '1;
    repeat (2) step();

    // Fill the order FIFO, overflow once, then retire one burst
    for (int i = 0; i < 9; i++) push_ar(i % 3, 0);
    beat(32'hF00D, RRESP_SLVERR, 1'b1);
    step();
    for (int i = 0; i < 10; i++) beat(32'h2000 + i, RRESP_OKAY, exp_slast());
    repeat (2) step();

    // Slave RLAST early on a len=2 burst
    push_ar(1, 2);
    beat(32'h3000, RRESP_OKAY, 1'b0);
    beat(32'h3001, RRESP_OKAY, 1'b1);
    beat(32'h3002, RRESP_DECERR, 1'b0);
    repeat (2) step();

    // Reset in the middle of a len=3 burst
    push_ar(0, 3);
    beat(32'h4000, RRESP_OKAY, 1'b0);
    beat(32'h4001, RRESP_OKAY, 1'b0);
    ARESET_i = 1'b1;
    step();
    ARESET_i = 1'b0;
    step();
    push_ar(2, 0);
    beat(32'h5000, RRESP_EXOKAY, 1'b1);
    repeat (2) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      AR_fifo_order_wr_en_i = ($urandom_range(0, 3) == 0);
      AR_mst_id_i  = MST_ID_W'($urandom_range(0, MST_AMT - 1));
      AR_AxLEN_i   = LW'($urandom_range(0, 7));
      s_RVALID_i   = ($urandom_range(0, 3) != 0);
      s_RDATA_i    = $urandom;
      s_RRESP_i    = 2'($urandom_range(0, 3));
      s_RLAST_i    = exp_slast() ^ (i > 1500 && $urandom_range(0, 39) == 0);
      dsp_RREADY_i = 3'($urandom) | ((i % 4 == 0) ? 3'b111 : 3'b000);
      ARESET_i     = (i == 1000 || i == 2200);
      step();
    end
    ARESET_i = 1'b0;

    // Drain whatever is still outstanding
    idle_inputs();
    dsp_RREADY_i = '1;
    guard = 0;
    while ((txn_q.size() > 0 || out_q.size() > 0) && guard < 500) begin
      s_RVALID_i = 1'b1;
      s_RDATA_i  = $urandom;
      s_RLAST_i  = exp_slast();
      step();
      guard++;
    end
    s_RVALID_i = 1'b0;
    check_val("drain_done", guard < 500, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sa_rdata_channel.md
# sa_RDATA_channel

Slave-side read-data return path of the AXI4 interconnect, one instance per slave port. It accepts R beats from its slave and steers each beat to the master dispatcher that issued the matching AR request. The delivery order is the order in which this slave's read-address channel accepted the requests. Beat counting against the recorded ARLEN produces RLAST for the master and checks the slave's own RLAST.

## Interface
Parameters:
- MST_AMT, 3: number of masters.
- OUTSTANDING_AMT, 8: depth of the read-order FIFO (outstanding AR transactions).
- MST_ID_W, $clog2(MST_AMT): master index width.
- DATA_WIDTH, 32: RDATA width.
- TRANS_DATA_LEN_W, 3: ARLEN width (bursts of 1..2^TRANS_DATA_LEN_W beats).

Ports (one clock; reset is synchronous and active-high):
- ACLK_i  in  1  clock; all logic on rising edge.
- ARESET_i  in  1  synchronous active-high reset.
- AR_mst_id_i  in  MST_ID_W  master index of the accepted AR.
- AR_AxLEN_i  in  TRANS_DATA_LEN_W  ARLEN of the accepted AR.
- AR_fifo_order_wr_en_i  in  1  push {id, len} into order FIFO.
- AR_stall_o  out  1  order FIFO full; the AR channel must not push.
- s_RDATA_i  in  DATA_WIDTH  slave read data.
- s_RRESP_i  in  2  slave read response.
- s_RLAST_i  in  1  slave last beat.
- s_RVALID_i  in  1  slave beat valid.
- s_RREADY_o  out  1  ready to slave.
- dsp_RDATA_o  out  DATA_WIDTH*MST_AMT  per-master data; slice m = [DATA_WIDTH*(m+1)-1 -: DATA_WIDTH].
- dsp_RRESP_o  out  2*MST_AMT  per-master response.
- dsp_RLAST_o  out  MST_AMT  per-master last.
- dsp_RVALID_o  out  MST_AMT  per-master valid, at most one bit set.
- dsp_RREADY_i  in  MST_AMT  per-master ready.
- rlast_err_o  out  1  sticky RLAST mismatch flag.

## Operation
- **Order FIFO:** entries are {mst_id, len}.
  - Push when AR_fifo_order_wr_en_i=1 and the FIFO is not full. A push while full is dropped.
  - Pop on the slave handshake of a beat whose counted last is true.
  - A simultaneous push and pop is legal, and the occupancy is unchanged.
- **Beat counter:** beat_ctn_r, TRANS_DATA_LEN_W bits, reset 0.
  - counted_last = (beat_ctn_r == head.len).
  - On each slave handshake (s_RVALID_i & s_RREADY_o): if counted_last, beat_ctn_r <= 0; otherwise beat_ctn_r <= beat_ctn_r + 1.
- **Output register:** one stage holding out_valid, out_mst, out_data, out_resp, out_last.
  - On a slave handshake, load {1, head.mst_id, s_RDATA_i, s_RRESP_i, counted_last}.
  - On a downstream handshake (out_valid & dsp_RREADY_i[out_mst]) with no simultaneous load, clear out_valid.
- **Output steering:**
  - dsp_RVALID_o[m] = out_valid & (out_mst == m).
  - All data, resp and last slices are driven from the register regardless of m.
  - dsp_RLAST_o[m] = out_last & (out_mst == m).
- **Slave ready:** s_RREADY_o = ~order_empty & (~out_valid | dsp_RREADY_i[out_mst]). This gives full throughput: a load and a drain can happen in the same cycle.
- **RLAST check:** on a slave handshake where s_RLAST_i != counted_last, set rlast_err_o. It stays set until reset. Routing always follows counted_last, never s_RLAST_i.
- The RRESP value is passed through unmodified.

## Timing
- **Reset values:** s_RREADY_o=0, all dsp_RVALID_o=0, dsp_RLAST_o=0, data and resp outputs 0, AR_stall_o=0, rlast_err_o=0. The order FIFO is empty and beat_ctn_r=0.
- **Latency:** a beat accepted from the slave in cycle N appears on dsp_*_o in cycle N+1.
- **Handshake rules:**
  - A beat is held stable while dsp_RREADY_i[out_mst]=0.
  - s_RREADY_o has no combinational dependency on s_RVALID_i.
- **Order FIFO timing:**
  - A push is visible to s_RREADY_o in the next cycle. A beat can arrive 1 cycle after the AR push at the earliest.
  - AR_stall_o is asserted in the cycle after the push that fills the FIFO.
  - AR_stall_o is deasserted in the cycle after a pop.
- **Boundary conditions:**
  - Order FIFO empty: s_RREADY_o=0 even if s_RVALID_i=1.
  - len=0: every beat is last and pops the FIFO immediately.
  - Back-to-back bursts to different masters incur no bubble.
  - A reset asserted mid-burst discards the register contents, the FIFO and the counter.

## Structure
- Shared package constants: RRESP width (2) and encodings OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
- Reuse the codebase `fifo` module as the single sub-module for the order FIFO (DATA_WIDTH = MST_ID_W+TRANS_DATA_LEN_W, FIFO_DEPTH = OUTSTANDING_AMT).
- The counter, output register and steering logic are written inline.

## Test plan
- **Single beat:** push {id=2, len=0}; slave beat 0xA5A5A5A5 with RLAST=1 → dsp_RVALID_o=3'b100 one cycle later; slice 2 = 0xA5A5A5A5 with RLAST=1; FIFO empty afterwards.
- **Interleaved bursts, full throughput:** push {0,3} then {1,1}; slave sends 6 beats back-to-back with all readies high → master 0 gets 4 beats (last on beat 4), master 1 gets 2 beats, with no idle cycle between them.
- **Backpressure:** dsp_RREADY_i[0]=0 for 5 cycles mid-burst → s_RREADY_o=0 while the register is full; no beat lost or duplicated; data held stable.
- **Full FIFO:** 8 pushes with no data → AR_stall_o=1; the 9th push is ignored; one completed burst → AR_stall_o=0 the next cycle.
- **RLAST mismatch:** push {1,2}; slave asserts RLAST on beat 2 → rlast_err_o=1 sticky; routing still ends on beat 3.
- **Reset mid-burst:** assert ARESET_i for 1 cycle after beat 2 of len=3 → all outputs return to reset values; a new len=0 transaction then completes normally.
